// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Optional bubble counter: define ID_EX_BUBBLE_CNT_EN to add bubble_cnt_o.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid_i,
    input  logic [17:0]       id_ctl_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [4:0]        id_shamt_i,
    input  logic [DATA_W-1:0] id_pc4_i,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic              stall_o,
    output logic              ex_valid_o,
    output logic [17:0]       ex_ctl_o,
    output logic [REG_AW-1:0] ex_rs_o,
    output logic [REG_AW-1:0] ex_rt_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic [DATA_W-1:0] ex_rs_data_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [DATA_W-1:0] ex_pc4_o,
    output logic [4:0]        ex_shamt_o
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [31:0]       bubble_cnt_o
`endif
);

    localparam int MEM_READ_BIT = 13;

    logic              valid_q, valid_d;
    logic [17:0]       ctl_q, ctl_d;
    logic [REG_AW-1:0] rs_q, rs_d;
    logic [REG_AW-1:0] rt_q, rt_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic [4:0]        shamt_q, shamt_d;

    logic haz;
    logic bubble;
    logic capture;

    // Both sources compared regardless of opcode; $0 is never a dependency.
    always_comb begin
        haz = valid_q & ctl_q[MEM_READ_BIT] & id_valid_i
            & (rt_q != '0)
            & ((rt_q == id_rs_i) | (rt_q == id_rt_i));
    end

    assign stall_o = haz | hold_i;

    always_comb begin
        bubble  = ~hold_i & (flush_i | haz);
        capture = ~hold_i & ~flush_i & ~haz & id_valid_i;
    end

    always_comb begin
        valid_d   = valid_q;
        ctl_d     = ctl_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        pc4_d     = pc4_q;
        shamt_d   = shamt_q;
        if (capture) begin
            valid_d   = 1'b1;
            ctl_d     = id_ctl_i;
            rs_d      = id_rs_i;
            rt_d      = id_rt_i;
            rd_d      = id_rd_i;
            rs_data_d = id_rs_data_i;
            rt_data_d = id_rt_data_i;
            imm_d     = id_imm_i;
            pc4_d     = id_pc4_i;
            shamt_d   = id_shamt_i;
        end else if (!hold_i) begin
            // Flush, hazard or empty ID slot: fully cleared bubble.
            valid_d   = 1'b0;
            ctl_d     = '0;
            rs_d      = '0;
            rt_d      = '0;
            rd_d      = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            pc4_d     = '0;
            shamt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            ctl_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            pc4_q     <= '0;
            shamt_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            ctl_q     <= ctl_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            pc4_q     <= pc4_d;
            shamt_q   <= shamt_d;
        end
    end

    assign ex_valid_o   = valid_q;
    assign ex_ctl_o     = ctl_q;
    assign ex_rs_o      = rs_q;
    assign ex_rt_o      = rt_q;
    assign ex_rd_o      = rd_q;
    assign ex_rs_data_o = rs_data_q;
    assign ex_rt_data_o = rt_data_q;
    assign ex_imm_o     = imm_q;
    assign ex_pc4_o     = pc4_q;
    assign ex_shamt_o   = shamt_q;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed self-checking bench for id_ex_stage_reg.
// Also covers bubble_cnt_o when ID_EX_BUBBLE_CNT_EN is defined.
module tb_id_ex_stage_reg;

    localparam logic [17:0] CTL_SUB = 18'h10042;
    localparam logic [17:0] CTL_LW  = 18'h03007;
    localparam logic [17:0] CTL_ALL = 18'h3FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid_i;
    logic [17:0] id_ctl_i;
    logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
    logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i, id_pc4_i;
    logic [4:0]  id_shamt_i;
    logic        flush_i, hold_i;
    logic        stall_o, ex_valid_o;
    logic [17:0] ex_ctl_o;
    logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;
    logic [31:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_pc4_o;
    logic [4:0]  ex_shamt_o;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_o;
`endif

    int cmp = 0;
    int mis = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk),
        .reset(reset),
        .id_valid_i(id_valid_i),
        .id_ctl_i(id_ctl_i),
        .id_rs_i(id_rs_i),
        .id_rt_i(id_rt_i),
        .id_rd_i(id_rd_i),
        .id_rs_data_i(id_rs_data_i),
        .id_rt_data_i(id_rt_data_i),
        .id_imm_i(id_imm_i),
        .id_shamt_i(id_shamt_i),
        .id_pc4_i(id_pc4_i),
        .flush_i(flush_i),
        .hold_i(hold_i),
        .stall_o(stall_o),
        .ex_valid_o(ex_valid_o),
        .ex_ctl_o(ex_ctl_o),
        .ex_rs_o(ex_rs_o),
        .ex_rt_o(ex_rt_o),
        .ex_rd_o(ex_rd_o),
        .ex_rs_data_o(ex_rs_data_o),
        .ex_rt_data_o(ex_rt_data_o),
        .ex_imm_o(ex_imm_o),
        .ex_pc4_o(ex_pc4_o),
        .ex_shamt_o(ex_shamt_o)
`ifdef ID_EX_BUBBLE_CNT_EN
        ,
        .bubble_cnt_o(bubble_cnt_o)
`endif
    );

    task automatic drive(input logic v, input logic [17:0] c,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd);
        id_valid_i   = v;
        id_ctl_i     = c;
        id_rs_i      = rs;
        id_rt_i      = rt;
        id_rd_i      = rd;
        id_rs_data_i = 32'h1000_0000 | {27'd0, rs};
        id_rt_data_i = 32'h2000_0000 | {27'd0, rt};
        id_imm_i     = 32'hFFFF_FF00 | {27'd0, rd};
        id_shamt_i   = rd;
        id_pc4_i     = 32'h0040_0004;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush_i = 1'b0;
        hold_i  = 1'b0;
        drive(1'b0, 18'd0, 5'd0, 5'd0, 5'd0);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush_i = 1'b0;
        hold_i = 1'b0;
        drive(1'b0, 18'd0, 5'd0, 5'd0, 5'd0);
        tick();
        cmp++;
        if (ex_valid_o !== 1'b0 || ex_ctl_o !== 18'd0) begin
            mis++;
            $display("FAIL reset_init: valid=%b ctl=%h want 0/0", ex_valid_o, ex_ctl_o);
        end
        reset = 1'b0;
        drive(1'b1, CTL_ALL, 5'd1, 5'd2, 5'd3);
        tick();
        cmp++;
        if (ex_ctl_o !== CTL_ALL) begin
            mis++;
            $display("FAIL reset_preload: ctl=%h want %h", ex_ctl_o, CTL_ALL);
        end
        drive(1'b0, 18'd0, 5'd0, 5'd0, 5'd0);
        #3;
        reset = 1'b1;
        #1;
        cmp++;
        if (ex_valid_o !== 1'b0 || ex_ctl_o !== 18'd0 || ex_rd_o !== 5'd0
            || ex_imm_o !== 32'd0 || ex_pc4_o !== 32'd0 || stall_o !== 1'b0) begin
            mis++;
            $display("FAIL reset_async: v=%b ctl=%h rd=%0d imm=%h pc4=%h stall=%b want all 0",
                     ex_valid_o, ex_ctl_o, ex_rd_o, ex_imm_o, ex_pc4_o, stall_o);
        end
`ifdef ID_EX_BUBBLE_CNT_EN
        cmp++;
        if (bubble_cnt_o !== 32'd0) begin
            mis++;
            $display("FAIL reset_cnt: got %0d want 0", bubble_cnt_o);
        end
`endif
        tick();
        reset = 1'b0;
    endtask

    task automatic test_pass_through();
        idle();
        drive(1'b1, CTL_SUB, 5'd3, 5'd4, 5'd5);
        #1;
        cmp++;
        if (stall_o !== 1'b0) begin
            mis++;
            $display("FAIL pass_stall: got %b want 0", stall_o);
        end
        tick();
        cmp++;
        if (ex_valid_o !== 1'b1 || ex_ctl_o !== CTL_SUB || ex_rd_o !== 5'd5
            || ex_rs_o !== 5'd3 || ex_rt_o !== 5'd4) begin
            mis++;
            $display("FAIL pass_ctl: v=%b ctl=%h rs=%0d rt=%0d rd=%0d want 1 %h 3 4 5",
                     ex_valid_o, ex_ctl_o, ex_rs_o, ex_rt_o, ex_rd_o, CTL_SUB);
        end
        cmp++;
        if (ex_rs_data_o !== 32'h1000_0003 || ex_rt_data_o !== 32'h2000_0004
            || ex_imm_o !== 32'hFFFF_FF05 || ex_shamt_o !== 5'd5
            || ex_pc4_o !== 32'h0040_0004) begin
            mis++;
            $display("FAIL pass_data: rsd=%h rtd=%h imm=%h sh=%0d pc4=%h",
                     ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_shamt_o, ex_pc4_o);
        end
    endtask

    task automatic test_load_use();
        logic [31:0] c0;
        idle();
`ifdef ID_EX_BUBBLE_CNT_EN
        c0 = bubble_cnt_o;
`else
        c0 = 32'd0;
`endif
        drive(1'b1, CTL_LW, 5'd2, 5'd8, 5'd0);
        tick();
        drive(1'b1, CTL_SUB, 5'd8, 5'd9, 5'd10);
        #1;
        cmp++;
        if (stall_o !== 1'b1) begin
            mis++;
            $display("FAIL lu_stall: got %b want 1", stall_o);
        end
        tick();
        cmp++;
        if (ex_valid_o !== 1'b0 || ex_ctl_o !== 18'd0 || ex_rd_o !== 5'd0
            || ex_rs_data_o !== 32'd0 || stall_o !== 1'b0) begin
            mis++;
            $display("FAIL lu_bubble: v=%b ctl=%h rd=%0d rsd=%h stall=%b want 0 0 0 0 0",
                     ex_valid_o, ex_ctl_o, ex_rd_o, ex_rs_data_o, stall_o);
        end
`ifdef ID_EX_BUBBLE_CNT_EN
        cmp++;
        if (bubble_cnt_o !== c0 + 32'd1) begin
            mis++;
            $display("FAIL lu_cnt: got %0d want %0d", bubble_cnt_o, c0 + 32'd1);
        end
`endif
        tick();
        cmp++;
        if (ex_valid_o !== 1'b1 || ex_ctl_o !== CTL_SUB || ex_rs_o !== 5'd8
            || ex_rd_o !== 5'd10) begin
            mis++;
            $display("FAIL lu_capture: v=%b ctl=%h rs=%0d rd=%0d want 1 %h 8 10",
                     ex_valid_o, ex_ctl_o, ex_rs_o, ex_rd_o, CTL_SUB);
        end
        // rt-side match also counts
        drive(1'b1, CTL_LW, 5'd1, 5'd12, 5'd0);
        tick();
        drive(1'b1, CTL_SUB, 5'd7, 5'd12, 5'd13);
        #1;
        cmp++;
        if (stall_o !== 1'b1) begin
            mis++;
            $display("FAIL lu_rt_stall: got %b want 1", stall_o);
        end
        drive(1'b0, CTL_SUB, 5'd12, 5'd12, 5'd13);
        #1;
        cmp++;
        if (stall_o !== 1'b0) begin
            mis++;
            $display("FAIL lu_invalid_id: got %b want 0", stall_o);
        end
        drive(1'b1, CTL_SUB, 5'd7, 5'd6, 5'd13);
        #1;
        cmp++;
        if (stall_o !== 1'b0) begin
            mis++;
            $display("FAIL lu_nomatch: got %b want 0", stall_o);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        drive(1'b1, CTL_LW, 5'd2, 5'd0, 5'd0);
        tick();
        drive(1'b1, CTL_SUB, 5'd0, 5'd0, 5'd6);
        #1;
        cmp++;
        if (stall_o !== 1'b0) begin
            mis++;
            $display("FAIL zero_stall: got %b want 0", stall_o);
        end
        tick();
        cmp++;
        if (ex_valid_o !== 1'b1 || ex_ctl_o !== CTL_SUB || ex_rd_o !== 5'd6) begin
            mis++;
            $display("FAIL zero_capture: v=%b ctl=%h rd=%0d want 1 %h 6",
                     ex_valid_o, ex_ctl_o, ex_rd_o, CTL_SUB);
        end
    endtask

    task automatic test_back_to_back();
        idle();
        drive(1'b1, CTL_LW, 5'd2, 5'd8, 5'd0);
        tick();
        drive(1'b1, CTL_LW, 5'd8, 5'd9, 5'd0);
        #1;
        cmp++;
        if (stall_o !== 1'b1) begin
            mis++;
            $display("FAIL b2b_stall1: got %b want 1", stall_o);
        end
        tick();
        cmp++;
        if (stall_o !== 1'b0 || ex_valid_o !== 1'b0) begin
            mis++;
            $display("FAIL b2b_one_cycle: stall=%b v=%b want 0 0", stall_o, ex_valid_o);
        end
        tick();
        cmp++;
        if (ex_ctl_o !== CTL_LW || ex_rt_o !== 5'd9 || ex_valid_o !== 1'b1) begin
            mis++;
            $display("FAIL b2b_lw2: ctl=%h rt=%0d v=%b want %h 9 1",
                     ex_ctl_o, ex_rt_o, ex_valid_o, CTL_LW);
        end
        drive(1'b1, CTL_SUB, 5'd9, 5'd1, 5'd2);
        #1;
        cmp++;
        if (stall_o !== 1'b1) begin
            mis++;
            $display("FAIL b2b_stall2: got %b want 1", stall_o);
        end
    endtask

    task automatic test_flush_hold();
        logic [31:0] c0;
        idle();
        drive(1'b1, CTL_SUB, 5'd1, 5'd2, 5'd7);
        tick();
`ifdef ID_EX_BUBBLE_CNT_EN
        c0 = bubble_cnt_o;
`else
        c0 = 32'd0;
`endif
        flush_i = 1'b1;
        hold_i  = 1'b1;
        drive(1'b1, CTL_LW, 5'd11, 5'd12, 5'd13);
        tick();
        cmp++;
        if (ex_valid_o !== 1'b1 || ex_ctl_o !== CTL_SUB || ex_rd_o !== 5'd7
            || stall_o !== 1'b1) begin
            mis++;
            $display("FAIL fh_hold: v=%b ctl=%h rd=%0d stall=%b want 1 %h 7 1",
                     ex_valid_o, ex_ctl_o, ex_rd_o, stall_o, CTL_SUB);
        end
        hold_i = 1'b0;
        tick();
        cmp++;
        if (ex_valid_o !== 1'b0 || ex_ctl_o !== 18'd0 || ex_rd_o !== 5'd0) begin
            mis++;
            $display("FAIL fh_flush: v=%b ctl=%h rd=%0d want 0 0 0",
                     ex_valid_o, ex_ctl_o, ex_rd_o);
        end
`ifdef ID_EX_BUBBLE_CNT_EN
        cmp++;
        if (bubble_cnt_o !== c0 + 32'd1) begin
            mis++;
            $display("FAIL fh_cnt: got %0d want %0d", bubble_cnt_o, c0 + 32'd1);
        end
`endif
        flush_i = 1'b0;
        drive(1'b0, CTL_ALL, 5'd1, 5'd2, 5'd3);
        tick();
        cmp++;
        if (ex_valid_o !== 1'b0 || ex_ctl_o !== 18'd0) begin
            mis++;
            $display("FAIL invalid_capture: v=%b ctl=%h want 0 0", ex_valid_o, ex_ctl_o);
        end
    endtask

    task automatic test_hold();
        idle();
        drive(1'b1, CTL_SUB, 5'd14, 5'd15, 5'd16);
        tick();
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, CTL_LW ^ 18'(i), 5'(20 + i), 5'(21 + i), 5'(22 + i));
            #1;
            cmp++;
            if (stall_o !== 1'b1) begin
                mis++;
                $display("FAIL hold_stall_%0d: got %b want 1", i, stall_o);
            end
            tick();
            cmp++;
            if (ex_ctl_o !== CTL_SUB || ex_rd_o !== 5'd16 || ex_rs_o !== 5'd14
                || ex_valid_o !== 1'b1) begin
                mis++;
                $display("FAIL hold_stable_%0d: ctl=%h rd=%0d rs=%0d v=%b want %h 16 14 1",
                         i, ex_ctl_o, ex_rd_o, ex_rs_o, ex_valid_o, CTL_SUB);
            end
        end
        hold_i = 1'b0;
        drive(1'b1, CTL_SUB, 5'd17, 5'd18, 5'd19);
        tick();
        cmp++;
        if (ex_rd_o !== 5'd19 || stall_o !== 1'b0) begin
            mis++;
            $display("FAIL hold_release: rd=%0d stall=%b want 19 0", ex_rd_o, stall_o);
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_load_use();
        test_zero_reg();
        test_back_to_back();
        test_flush_hold();
        test_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS pipeline.
- Captures the decoded control bundle from the instruction decoder, plus register operands and immediates, and presents them to EX.
- Contains load-use hazard detection: on a hazard it inserts a bubble into EX and stalls IF/ID.
- Also handles flush (taken branch/jump) and downstream hold (multi-cycle EX op).

Parameters:
- DATA_W, 32, operand/immediate/PC width
- REG_AW, 5, register address width

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous active-high reset
- id_valid_i  input  1  ID holds a real instruction
- id_ctl_i  input  18  decoder bundle, MSB..LSB: reg_src, reg_dst, jump, branch, mem_read, mem_to_reg, alu_op[5:0], mem_wr, alu_src[2:0], reg_wr, sign_ext
- id_rs_i / id_rt_i / id_rd_i  input  REG_AW  each  source/dest register numbers
- id_rs_data_i / id_rt_data_i  input  DATA_W  each  register file read data
- id_imm_i  input  DATA_W  extended immediate
- id_shamt_i  input  5  shift amount
- id_pc4_i  input  DATA_W  PC+4 of ID instruction
- flush_i  input  1  squash the ID instruction (branch/jump redirect)
- hold_i  input  1  EX busy; freeze ID/EX
- stall_o  output  1  freeze PC and IF/ID this cycle
- ex_valid_o  output  1  EX holds a real instruction
- ex_ctl_o  output  18  registered control bundle
- ex_rs_o / ex_rt_o / ex_rd_o  output  REG_AW  each  registered register numbers
- ex_rs_data_o / ex_rt_data_o / ex_imm_o / ex_pc4_o  output  DATA_W  each  registered data
- ex_shamt_o  output  5  registered shamt

Behaviour:
- Reset (async, immediate): all outputs 0. ex_valid_o=0, ex_ctl_o=18'b0, which is a NOP.
- Latency: 1 cycle, ID inputs to EX outputs.
- Hazard (combinational):
  - haz = ex_valid_o & ex_ctl_o.mem_read & id_valid_i & (ex_rt_o != 0) & ((ex_rt_o == id_rs_i) | (ex_rt_o == id_rt_i))
  - Conservative: both sources are compared regardless of opcode.
- stall_o = haz | hold_i. Purely combinational, no registered delay.
- Per-edge priority:
  1. reset
  2. hold_i=1: all registers keep their value, including when flush_i or haz is also active. A flush arriving during a hold is not lost: the redirect logic keeps flush_i asserted until the hold releases.
  3. flush_i=1: load a bubble.
  4. haz=1: load a bubble. The ID instruction stays in IF/ID because stall_o=1, and is re-presented next cycle.
  5. Otherwise: capture all id_* inputs; ex_valid_o <= id_valid_i.
- Bubble definition:
  - ex_valid_o=0 and ex_ctl_o=18'b0, so reg_wr, mem_wr, mem_read, branch and jump are all 0.
  - Data fields are also cleared to 0, giving a deterministic trace.
- id_valid_i=0 with no hold/flush/haz: captured as a bubble (ctl forced to 0).
- Back-to-back loads: a hazard lasts exactly 1 cycle, because after the bubble ex_valid_o=0.
- Register 0 never causes a hazard.

Optional Feature:
- Macro ID_EX_BUBBLE_CNT_EN.
- When defined:
  - Adds output bubble_cnt_o [31:0], reset to 0.
  - Increments by 1 on each edge where a bubble is loaded due to haz or flush_i (not hold_i).
  - Wraps from 32'hFFFFFFFF to 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-run: assert reset asynchronously between edges with ex_ctl_o=18'h3FFFF -> all outputs 0 immediately, stall_o=0.
- Pass-through: id_ctl_i=18'b0_1_0_0_0_0_000001_0_000_1_0 (SUB), rs=3, rt=4, rd=5, valid -> next edge ex_ctl_o equals input, ex_rd_o=5, ex_valid_o=1, stall_o=0.
- Load-use: EX holds LW (mem_read=1) with ex_rt_o=8; ID holds ADD with rs=8 -> stall_o=1; next edge ex_valid_o=0, ex_ctl_o=0; next edge ADD captured, stall_o=0.
- $0 exemption: EX holds LW with rt=0; ID uses rs=0 -> stall_o=0 and ID is captured normally.
- Flush vs hold: flush_i=1, hold_i=1 -> outputs unchanged; hold_i drops, flush_i still 1 -> bubble loaded; with ID_EX_BUBBLE_CNT_EN, bubble_cnt_o goes 0->1.
- Hold: hold_i=1 for 3 cycles while ID changes -> ex_* stable for all 3 cycles, stall_o=1 throughout.
